sprite_compositor: RTL and testbench

- Parametrised N-channel sprite compositor that replaces the fixed-priority, single-sprite-per-branch colour path in the VGA display.
- Sits between the VGA controller's DrawX/DrawY/blank stream and the RGB outputs.
- Per channel: frame-shadowed position, enable and animation frame; a synchronous sprite-ROM read port; colour-key transparency with fall-through to lower layers.
- Also produces per-frame collision flags between the player sprite (channel 0) and every other channel, with fixed, documented pipeline latency.

---
 rtl/sprite_compositor_pkg.sv | 24 ++
 rtl/sprite_compositor_channel.sv | 62 ++++++
 rtl/sprite_compositor.sv | 130 +++++++++++++
 tb/tb_sprite_compositor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared types and defaults for the sprite compositor.
// Holds the colour/position types and the animation-frame base-address helper.
package sprite_compositor_pkg;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
        logic [1:0] frame;
    } spr_pos_t;

    localparam rgb_t       KEY_RGB_DEF = 24'h000000;
    localparam int         CLIP_X_DEF  = 405;
    localparam int unsigned PIX_DEF    = 26 * 26;

    // Start address of an animation frame inside one channel's sprite ROM.
    function automatic logic [31:0] frame_base(input logic [1:0] frame,
                                               input int unsigned pix_per_frame = PIX_DEF);
        return 32'(frame) * pix_per_frame;
    endfunction

endpackage

// File: rtl/sprite_compositor_channel.sv
// One sprite channel: frame-shadowed position, stage-1 hit test and ROM
// address generation, plus the hit flag delayed to line up with ROM data.
module sprite_channel
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_W  = 26,
    parameter int SPR_H  = 26,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  spr_pos_t          pos,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              hit_d2
);

    localparam int unsigned PIX = SPR_W * SPR_H;

    spr_pos_t    shadow;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        hit;
    logic        hit_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow <= '0;
        else if (frame_start)
            shadow <= pos;
    end

    // 11-bit sums so a sprite near the right/bottom edge clips instead of wrapping.
    assign x_end = {1'b0, shadow.x} + 11'(SPR_W);
    assign y_end = {1'b0, shadow.y} + 11'(SPR_H);
    assign dx    = {1'b0, draw_x} - {1'b0, shadow.x};
    assign dy    = {1'b0, draw_y} - {1'b0, shadow.y};

    assign hit = shadow.en
               && (draw_x >= shadow.x) && ({1'b0, draw_x} < x_end)
               && (draw_y >= shadow.y) && ({1'b0, draw_y} < y_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            hit_d1   <= 1'b0;
            hit_d2   <= 1'b0;
        end else begin
            if (hit)
                rom_addr <= ADDR_W'(frame_base(shadow.frame, PIX))
                          + ADDR_W'(dy) * ADDR_W'(SPR_W)
                          + ADDR_W'(dx);
            hit_d1 <= hit;
            hit_d2 <= hit_d1;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: per-channel ROM lookup, colour-key priority mux,
// right-edge clipping and per-frame player collision flags. DrawX -> RGB is 3 Clk.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int   NCH     = 4,
    parameter int   SPR_W   = 26,
    parameter int   SPR_H   = 26,
    parameter int   NFRAMES = 4,
    parameter int   ADDR_W  = 12,
    parameter int   CLIP_X  = CLIP_X_DEF,
    parameter rgb_t KEY_RGB = KEY_RGB_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_start,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       blank,
    input  logic [23:0]                bg_rgb,
    input  logic [NCH-1:0][9:0]        spr_x,
    input  logic [NCH-1:0][9:0]        spr_y,
    input  logic [NCH-1:0]             spr_en,
    input  logic [NCH-1:0][1:0]        spr_frame,
    output logic [NCH-1:0][ADDR_W-1:0] rom_addr,
    input  logic [NCH-1:0][23:0]       rom_data,
    output logic [7:0]                 Red,
    output logic [7:0]                 Green,
    output logic [7:0]                 Blue,
    output logic [NCH-1:0]             collide,
    output logic                       collide_valid
);

    localparam logic [10:0]    CLIP_X_L  = 11'(CLIP_X);
    localparam logic [NCH-1:0] NOT_PLAYER = ~NCH'(1);

    if (ADDR_W < $clog2(NFRAMES * SPR_W * SPR_H)) begin : g_addr_check
        $error("ADDR_W too narrow for NFRAMES*SPR_W*SPR_H");
    end

    logic [NCH-1:0] hit_d2;
    spr_pos_t       pos [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign pos[i] = '{x: spr_x[i], y: spr_y[i], en: spr_en[i], frame: spr_frame[i]};

        sprite_channel #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .ADDR_W(ADDR_W)
        ) u_ch (
            .clk        (Clk),
            .rst        (Reset),
            .frame_start(frame_start),
            .draw_x     (DrawX),
            .draw_y     (DrawY),
            .pos        (pos[i]),
            .rom_addr   (rom_addr[i]),
            .hit_d2     (hit_d2[i])
        );
    end

    logic blank_d1, blank_d2;
    logic clip_d1, clip_d2;
    rgb_t bg_d1, bg_d2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blank_d1 <= 1'b0;
            blank_d2 <= 1'b0;
            clip_d1  <= 1'b0;
            clip_d2  <= 1'b0;
            bg_d1    <= '0;
            bg_d2    <= '0;
        end else begin
            blank_d1 <= blank;
            blank_d2 <= blank_d1;
            clip_d1  <= ({1'b0, DrawX} >= CLIP_X_L);
            clip_d2  <= clip_d1;
            bg_d1    <= bg_rgb;
            bg_d2    <= bg_d1;
        end
    end

    logic [NCH-1:0] opaque;
    logic [NCH-1:0] col_now;
    logic           visible;
    rgb_t           pix;

    always_comb begin
        opaque  = '0;
        col_now = '0;
        visible = blank_d2 && !clip_d2;
        pix     = bg_d2;
        for (int i = 0; i < NCH; i++)
            opaque[i] = hit_d2[i] && (rom_data[i] != KEY_RGB);
        // Walk from lowest priority up so the lowest opaque index wins.
        for (int i = NCH - 1; i >= 0; i--)
            if (opaque[i])
                pix = rom_data[i];
        if (!visible)
            pix = '0;
        for (int i = 1; i < NCH; i++)
            col_now[i] = visible && opaque[0] && opaque[i];
    end

    logic [NCH-1:0] acc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red           <= '0;
            Green         <= '0;
            Blue          <= '0;
            acc           <= '0;
            collide       <= '0;
            collide_valid <= 1'b0;
        end else begin
            {Red, Green, Blue} <= pix;
            collide_valid      <= frame_start;
            // A collision on the frame_start cycle lands in the fresh accumulator.
            if (frame_start) begin
                collide <= acc & NOT_PLAYER;
                acc     <= col_now;
            end else begin
                acc     <= acc | col_now;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: vector table plus hand-written
// frame/collision sequences, RGB checked through a latency-stamped queue.
module tb_sprite_compositor;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [9:0]        draw_x, draw_y;
    logic              blank;
    logic [23:0]       bg;
    logic [3:0][9:0]   spr_x, spr_y;
    logic [3:0]        spr_en;
    logic [3:0][1:0]   spr_frame;
    logic [3:0][11:0]  rom_addr;
    logic [3:0][23:0]  rom_data;
    logic [7:0]        red, green, blue;
    logic [3:0]        collide;
    logic              collide_valid;

    sprite_compositor dut (
        .Clk          (clk),
        .Reset        (rst),
        .frame_start  (frame_start),
        .DrawX        (draw_x),
        .DrawY        (draw_y),
        .blank        (blank),
        .bg_rgb       (bg),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_en       (spr_en),
        .spr_frame    (spr_frame),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .Red          (red),
        .Green        (green),
        .Blue         (blue),
        .collide      (collide),
        .collide_valid(collide_valid)
    );

    // clock / reset / bookkeeping
    always #5 clk = ~clk;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cycle <= cycle + 1;

    logic [23:0] rom_mem [4][4096];

    function automatic logic [23:0] rom_init(input int ch, input int addr);
        return {4'(ch + 1), 4'h0, 16'(addr)};
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            rom_data[i] <= rom_mem[i][rom_addr[i]];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // scoreboard
    logic [23:0] exp_q[$];
    int          due_q[$];

    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] <= cycle) begin
            if (due_q[0] != cycle)
                check("rgb_latency", 32'(cycle), 32'(due_q[0]));
            check("rgb", {8'h0, red, green, blue}, {8'h0, exp_q[0]});
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_px(input logic [9:0] x, input logic [9:0] y, input logic b,
                            input logic [23:0] bgc, input logic [23:0] exp);
        draw_x = x;
        draw_y = y;
        blank  = b;
        bg     = bgc;
        exp_q.push_back(exp);
        due_q.push_back(cycle + 3);
        tick();
        blank  = 1'b0;
    endtask

    task automatic set_spr(input int ch, input logic [9:0] x, input logic [9:0] y,
                           input logic [1:0] fr);
        spr_x[ch]     = x;
        spr_y[ch]     = y;
        spr_frame[ch] = fr;
    endtask

    task automatic do_frame(input logic [3:0] en, input logic [3:0] exp_col);
        spr_en      = en;
        frame_start = 1'b1;
        blank       = 1'b0;
        tick();
        frame_start = 1'b0;
        check("collide_valid_pulse", 32'(collide_valid), 32'd1);
        check("collide", 32'(collide), 32'(exp_col));
        tick();
        check("collide_valid_drop", 32'(collide_valid), 32'd0);
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic [23:0] bgc;
        logic [23:0] exp_rgb;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 4096; a++)
                rom_mem[c][a] = rom_init(c, a);
        rom_mem[0][0] = 24'hFFFF00;

        rst = 1'b1; frame_start = 1'b0; blank = 1'b0;
        draw_x = '0; draw_y = '0; bg = '0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_frame = '0;
        idle(3);
        rst = 1'b0;
        tick();

        check("reset_rgb", {8'h0, red, green, blue}, 32'h0);
        check("reset_addr0", 32'(rom_addr[0]), 32'h0);
        check("reset_collide", 32'(collide), 32'h0);
        check("reset_collide_valid", 32'(collide_valid), 32'h0);

        // live enable alone must not draw before the first frame_start
        set_spr(0, 100, 50, 0);
        spr_en = 4'b0001;
        drive_px(100, 50, 1'b1, 24'h0A0B0C, 24'h0A0B0C);
        idle(4);

        do_frame(4'b0001, 4'b0000);
        drive_px(101, 51, 1'b1, 24'h010101, rom_init(0, 27));
        check("addr_101_51", 32'(rom_addr[0]), 32'd27);
        drive_px(100, 50, 1'b1, 24'h010101, 24'hFFFF00);
        check("addr_100_50", 32'(rom_addr[0]), 32'd0);
        idle(4);

        // asynchronous reset while a sprite pixel is on the outputs
        drive_px(101, 51, 1'b1, 24'h010101, rom_init(0, 27));
        idle(2);
        #5;
        rst = 1'b1;
        #1;
        check("async_reset_rgb", {8'h0, red, green, blue}, 32'h0);
        check("async_reset_addr", 32'(rom_addr[0]), 32'h0);
        check("async_reset_collide_valid", 32'(collide_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_px(101, 51, 1'b1, 24'h0A0B0C, 24'h0A0B0C);
        idle(4);

        // frame 2 addressing and right/bottom boundaries
        vecs[0] = '{10'd125, 10'd75, 1'b1, 24'h112233, rom_init(0, 2027), 12'd2027};
        vecs[1] = '{10'd126, 10'd75, 1'b1, 24'h112233, 24'h112233,        12'd2027};
        vecs[2] = '{10'd125, 10'd76, 1'b1, 24'h445566, 24'h445566,        12'd2027};
        vecs[3] = '{10'd99,  10'd50, 1'b1, 24'h778899, 24'h778899,        12'd2027};
        vecs[4] = '{10'd100, 10'd50, 1'b1, 24'h778899, rom_init(0, 1352), 12'd1352};
        vecs[5] = '{10'd112, 10'd60, 1'b1, 24'h778899, rom_init(0, 1624), 12'd1624};
        vecs[6] = '{10'd112, 10'd60, 1'b0, 24'h778899, 24'h000000,        12'd1624};
        set_spr(0, 100, 50, 2);
        do_frame(4'b0001, 4'b0000);
        for (int i = 0; i < 7; i++) begin
            drive_px(vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].bgc, vecs[i].exp_rgb);
            check($sformatf("vec%0d_addr", i), 32'(rom_addr[0]), 32'(vecs[i].exp_addr));
        end
        idle(4);

        // mid-frame live move is ignored until the next frame_start
        set_spr(0, 100, 50, 0);
        do_frame(4'b0001, 4'b0000);
        drive_px(100, 50, 1'b1, 24'h123456, 24'hFFFF00);
        spr_x[0] = 10'd150;
        drive_px(150, 50, 1'b1, 24'h123456, 24'h123456);
        drive_px(100, 50, 1'b1, 24'h123456, 24'hFFFF00);
        idle(4);
        do_frame(4'b0001, 4'b0000);
        drive_px(150, 50, 1'b1, 24'h654321, 24'hFFFF00);
        drive_px(100, 50, 1'b1, 24'h654321, 24'h654321);
        idle(4);

        // transparency fall-through, then opaque overlap and collision
        set_spr(0, 190, 190, 0);
        set_spr(1, 195, 195, 0);
        rom_mem[0][270] = 24'h000000;
        do_frame(4'b0011, 4'b0000);
        drive_px(200, 200, 1'b1, 24'h0F0F0F, rom_init(1, 135));
        idle(4);
        rom_mem[0][270] = 24'hABCDEF;
        drive_px(200, 200, 1'b1, 24'h0F0F0F, 24'hABCDEF);
        drive_px(190, 190, 1'b1, 24'h0F0F0F, 24'hFFFF00);
        idle(4);
        do_frame(4'b0011, 4'b0010);

        // clipping and blanking: black and no collision
        set_spr(0, 400, 50, 0);
        set_spr(1, 400, 50, 0);
        do_frame(4'b0011, 4'b0000);
        drive_px(410, 55, 1'b1, 24'hFFFFFF, 24'h000000);
        drive_px(404, 55, 1'b0, 24'hFFFFFF, 24'h000000);
        idle(4);
        set_spr(0, 190, 190, 0);
        set_spr(1, 195, 195, 0);
        do_frame(4'b0011, 4'b0000);

        // collision pixel reaching stage 3 on the frame_start cycle
        drive_px(200, 200, 1'b1, 24'h0F0F0F, 24'hABCDEF);
        idle(1);
        do_frame(4'b0011, 4'b0000);
        idle(4);
        do_frame(4'b0011, 4'b0010);

        idle(5);
        if (due_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected pixels never produced, required 0", due_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
